// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter. Each word goes out as 1001 sync, then payload MSB first, then optional even parity.
// Latency: the first sync bit appears the cycle after the accepting edge, and the last bit appears L = 4+DATA_W+PARITY_EN cycles after that edge.
// Backpressure: tx_ready is high in IDLE and on the last bit of a frame, so frames can run back to back with no gap.
// Ports: clk/rst (async active-high); tx_data/tx_valid/tx_ready input handshake;
//        dout/dout_en serial output; busy while a frame runs; frame_done on the last bit.
module sync_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              frame_done
);

  // The counter must reach 3 in SYNC even for very narrow payloads.
  localparam int CW_RAW = $clog2(DATA_W + 1);
  localparam int CW     = (CW_RAW < 2) ? 2 : CW_RAW;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;

  state_t            state, nxt_state;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic [DATA_W-1:0] shreg, nxt_shreg;
  logic              par, nxt_par;
  logic              take, at_last, nxt_last, nxt_dout;

  function automatic logic is_last(state_t s, logic [CW-1:0] c);
    is_last = (s == S_PAR) ||
              ((s == S_DATA) && (c == CW'(DATA_W - 1)) && (PARITY_EN == 0));
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_shreg = shreg;
    nxt_par   = par;
    take      = tx_valid && tx_ready;
    at_last   = is_last(state, cnt);

    case (state)
      S_SYNC: begin
        if (cnt == CW'(3)) begin
          nxt_state = S_DATA;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      S_DATA: begin
        // The current payload bit is always the MSB of the shift register.
        nxt_shreg = shreg << 1;
        if (cnt == CW'(DATA_W - 1)) begin
          nxt_state = (PARITY_EN != 0) ? S_PAR : S_IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: ;
    endcase

    // From IDLE or the last frame bit, either load a new word or stay idle.
    if ((state == S_IDLE) || at_last) begin
      nxt_cnt = '0;
      if (take) begin
        nxt_state = S_SYNC;
        nxt_shreg = tx_data;
        nxt_par   = ^tx_data;
      end else begin
        nxt_state = S_IDLE;
      end
    end

    // Output values for the next cycle are derived from the next state so the
    // ports can be driven straight from flops.
    case (nxt_state)
      S_SYNC:  nxt_dout = (nxt_cnt == '0) || (nxt_cnt == CW'(3));
      S_DATA:  nxt_dout = nxt_shreg[DATA_W-1];
      S_PAR:   nxt_dout = nxt_par;
      default: nxt_dout = 1'b0;
    endcase
    nxt_last = is_last(nxt_state, nxt_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_ready   <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      shreg      <= nxt_shreg;
      par        <= nxt_par;
      dout       <= nxt_dout;
      dout_en    <= (nxt_state != S_IDLE);
      busy       <= (nxt_state != S_IDLE);
      frame_done <= nxt_last;
      tx_ready   <= (nxt_state == S_IDLE) || nxt_last;
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Testbench for sync_frame_tx: one instance without parity and one with parity, both with 8-bit payloads.
// A frame-level reference model tracks the expected output of each instance on every cycle.
// Stimulus is applied 1 time unit after the rising edge, and outputs are sampled on the falling edge.
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld [2];
  logic [7:0] dat [2];
  logic       rdy [2];
  logic       dout[2];
  logic       en  [2];
  logic       bsy [2];
  logic       done[2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_frame_tx #(.DATA_W(8), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .dout(dout[0]), .dout_en(en[0]), .busy(bsy[0]), .frame_done(done[0]));

  sync_frame_tx #(.DATA_W(8), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .dout(dout[1]), .dout_en(en[1]), .busy(bsy[1]), .frame_done(done[1]));

  // ---------------- reference model: a bit list per frame plus a position ----------------
  logic m_bits[2][13];
  int   m_idx [2];
  bit   m_act [2];
  bit   m_up  [2];  // the model has seen a clock edge since reset was released

  function automatic int flen(int i);
    flen = (i == 0) ? 12 : 13;
  endfunction

  function automatic bit m_ready(int i);
    m_ready = m_act[i] ? (m_idx[i] == flen(i) - 1) : m_up[i];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0;
        m_up[i]  = 1'b0;
        m_idx[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit tk;
        tk = vld[i] && m_ready(i);
        if (m_act[i] && m_idx[i] < flen(i) - 1) begin
          m_idx[i]++;
        end else if (tk) begin
          m_bits[i][0] = 1'b1; m_bits[i][1] = 1'b0;
          m_bits[i][2] = 1'b0; m_bits[i][3] = 1'b1;
          for (int j = 0; j < 8; j++) m_bits[i][4+j] = dat[i][7-j];
          m_bits[i][12] = ^dat[i];
          m_idx[i] = 0;
          m_act[i] = 1'b1;
        end else begin
          m_act[i] = 1'b0;
        end
        m_up[i] = 1'b1;
      end
    end
  end

  // {dout, dout_en, busy, frame_done, tx_ready}
  function automatic logic [4:0] mexp(int i);
    logic lst;
    if (m_act[i]) begin
      lst  = (m_idx[i] == flen(i) - 1);
      mexp = {m_bits[i][m_idx[i]], 1'b1, 1'b1, lst, lst};
    end else begin
      mexp = {4'b0000, m_up[i]};
    end
  endfunction

  function automatic logic [4:0] obs(int i);
    obs = {dout[i], en[i], bsy[i], done[i], rdy[i]};
  endfunction

  task automatic drain();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    vld[0] = 1'b1; vld[1] = 1'b1;
    dat[0] = 8'h3C; dat[1] = 8'hC3;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== 5'b0) begin
          n_err++;
          $display("FAIL reset_outputs dut%0d got=%b want=00000", i, obs(i));
        end
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== 5'b0) begin
        n_err++;
        $display("FAIL reset_release_pre_edge dut%0d got=%b want=00000", i, obs(i));
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({en[i], rdy[i]} !== 2'b01) begin
        n_err++;
        $display("FAIL reset_first_edge_ready dut%0d got en,rdy=%b%b want=01", i, en[i], rdy[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({en[i], dout[i]} !== 2'b11) begin
        n_err++;
        $display("FAIL reset_frame_start dut%0d got en,dout=%b%b want=11", i, en[i], dout[i]);
      end
    end
    vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (14) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== mexp(i)) begin
          n_err++;
          $display("FAIL reset_drain dut%0d got=%b want=%b", i, obs(i), mexp(i));
        end
      end
    end
    drain();
  endtask

  task automatic test_single();
    logic [11:0] got;
    vld[0] = 1'b1; dat[0] = 8'hA5;
    @(posedge clk); #1;
    vld[0] = 1'b0; dat[0] = 8'($urandom);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      got[11-k] = dout[0];
      n_cmp++;
      if (obs(0) !== mexp(0)) begin
        n_err++;
        $display("FAIL single_cycle%0d got=%b want=%b", k + 1, obs(0), mexp(0));
      end
      if (k == 11) begin
        n_cmp++;
        if (done[0] !== 1'b1) begin
          n_err++;
          $display("FAIL single_frame_done got=%b want=1", done[0]);
        end
      end
    end
    n_cmp++;
    if (got !== 12'b1001_1010_0101) begin
      n_err++;
      $display("FAIL single_bits got=%b want=100110100101", got);
    end
    @(negedge clk);
    n_cmp++;
    if ({dout[0], en[0], bsy[0]} !== 3'b000) begin
      n_err++;
      $display("FAIL single_idle_after got=%b want=000", {dout[0], en[0], bsy[0]});
    end
    drain();
  endtask

  task automatic test_parity();
    logic [12:0] got;
    vld[1] = 1'b1; dat[1] = 8'h07;
    @(posedge clk); #1;
    vld[1] = 1'b0; dat[1] = 8'($urandom);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      got[12-k] = dout[1];
      n_cmp++;
      if (obs(1) !== mexp(1)) begin
        n_err++;
        $display("FAIL parity_cycle%0d got=%b want=%b", k + 1, obs(1), mexp(1));
      end
    end
    n_cmp++;
    if (got !== 13'b1001_00000111_1) begin
      n_err++;
      $display("FAIL parity_bits got=%b want=1001000001111", got);
    end
    @(negedge clk);
    n_cmp++;
    if (en[1] !== 1'b0) begin
      n_err++;
      $display("FAIL parity_len got en=%b at cycle 14 want=0", en[1]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [23:0] seq, ens, rdys;
    vld[0] = 1'b1; dat[0] = 8'hFF;
    @(posedge clk); #1;
    dat[0] = 8'h00;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      seq[23-k]  = dout[0];
      ens[23-k]  = en[0];
      rdys[23-k] = rdy[0];
      n_cmp++;
      if (obs(0) !== mexp(0)) begin
        n_err++;
        $display("FAIL b2b_cycle%0d got=%b want=%b", k + 1, obs(0), mexp(0));
      end
      if (k == 12) vld[0] = 1'b0;
    end
    n_cmp++;
    if (seq !== 24'b1001_11111111_1001_00000000) begin
      n_err++;
      $display("FAIL b2b_bits got=%b want=100111111111100100000000", seq);
    end
    n_cmp++;
    if (ens !== 24'hFFFFFF) begin
      n_err++;
      $display("FAIL b2b_dout_en got=%h want=ffffff", ens);
    end
    n_cmp++;
    if (rdys !== 24'h001001) begin
      n_err++;
      $display("FAIL b2b_ready got=%h want=001001", rdys);
    end
    @(negedge clk);
    n_cmp++;
    if (en[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_after got en=%b want=0", en[0]);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    logic [7:0]  d2;
    logic [11:0] got;
    vld[0] = 1'b1; dat[0] = 8'($urandom);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs(0) !== mexp(0)) begin
        n_err++;
        $display("FAIL midrst_cycle%0d got=%b want=%b", k + 1, obs(0), mexp(0));
      end
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs(0) !== 5'b0) begin
      n_err++;
      $display("FAIL midrst_async_clear got=%b want=00000", obs(0));
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (done[0] !== 1'b0 || obs(0) !== mexp(0)) begin
        n_err++;
        $display("FAIL midrst_no_done got=%b want=%b", obs(0), mexp(0));
      end
    end
    @(posedge clk); #1;
    d2 = 8'($urandom);
    vld[0] = 1'b1; dat[0] = d2;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      got[11-k] = dout[0];
      n_cmp++;
      if (obs(0) !== mexp(0)) begin
        n_err++;
        $display("FAIL midrst_refrm_cycle%0d got=%b want=%b", k + 1, obs(0), mexp(0));
      end
    end
    n_cmp++;
    if (got !== {4'b1001, d2}) begin
      n_err++;
      $display("FAIL midrst_refrm_bits got=%b want=%b", got, {4'b1001, d2});
    end
    drain();
  endtask

  task automatic test_stall();
    logic [7:0]  d;
    logic [11:0] got;
    d = 8'($urandom);
    vld[0] = 1'b1; dat[0] = d;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      got[11-k] = dout[0];
      n_cmp++;
      if (obs(0) !== mexp(0)) begin
        n_err++;
        $display("FAIL stall_cycle%0d got=%b want=%b", k + 1, obs(0), mexp(0));
      end
      vld[0] = (k < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      dat[0] = 8'($urandom);
    end
    n_cmp++;
    if (got !== {4'b1001, d}) begin
      n_err++;
      $display("FAIL stall_bits got=%b want=%b", got, {4'b1001, d});
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({en[0], dout[0]} !== 2'b00) begin
        n_err++;
        $display("FAIL stall_idle got en,dout=%b%b want=00", en[0], dout[0]);
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        dat[i] = 8'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== mexp(i)) begin
          n_err++;
          $display("FAIL random_c%0d dut%0d got=%b want=%b", c, i, obs(i), mexp(i));
        end
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  initial begin
    vld[0] = 1'b0; vld[1] = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_mid_reset();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
